// File: rtl/cmp_rr_arbiter_pkg.sv
// Shared constants for the round-robin comparator arbiter: output slot
// encoding, result flag positions and the id-width helper.
package cmp_arb_pkg;

   // Output slot states (kept as plain vectors for legacy tooling)
   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   // Bit positions of the registered result flags
   localparam int FLAG_EQ = 0;
   localparam int FLAG_GR = 1;
   localparam int FLAG_LE = 2;
   localparam int N_FLAGS = 3;

   // Smallest r with 2**r >= n; used to size requester ids
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/cmp_rr_arbiter_if.sv
// Request/result bundle between the client blocks (master) and the
// shared comparator arbiter (slave).
interface cmp_rr_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int W     = 4
);
   import cmp_arb_pkg::*;

   localparam int IDW = clog2(N_REQ);

   logic [N_REQ-1:0]   req_valid;
   logic [N_REQ*W-1:0] req_a;
   logic [N_REQ*W-1:0] req_b;
   logic [N_REQ-1:0]   req_ready;

   logic               res_valid;
   logic               res_ready;
   logic [IDW-1:0]     res_id;
   logic               res_eq;
   logic               res_gr;
   logic               res_le;
   logic [7:0]         res_count;

   modport master (
      output req_valid, req_a, req_b, res_ready,
      input  req_ready, res_valid, res_id, res_eq, res_gr, res_le, res_count
   );

   modport slave (
      input  req_valid, req_a, req_b, res_ready,
      output req_ready, res_valid, res_id, res_eq, res_gr, res_le, res_count
   );

endinterface

// File: rtl/cmp_rr_arbiter_mag_cmp.sv
// Unsigned W-bit magnitude comparator; exactly one output is high.
module mag_cmp #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         eq,
   output logic         gr,
   output logic         le
);

   assign eq = (a == b);
   assign gr = (a >  b);
   assign le = (a <  b);

endmodule

// File: rtl/cmp_rr_arbiter.sv
// Round-robin arbiter sharing one magnitude comparator between N_REQ
// requesters. One grant per cycle; the tagged result lands in a one-entry
// output slot the cycle after the handshake and is held under backpressure.
module cmp_rr_arbiter
   import cmp_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int W     = 4
) (
   input  logic            clk,
   input  logic            rst,
   cmp_rr_arbiter_if.slave bus
);

   localparam int IDW = clog2(N_REQ);

   logic [IDW-1:0]     rr_ptr;
   logic [IDW-1:0]     nxt_ptr;
   logic [N_REQ-1:0]   gnt;
   logic [IDW-1:0]     gnt_id;
   logic               gnt_any;
   logic               can_accept;

   logic [0:0]         state;
   logic               res_valid;
   logic [IDW-1:0]     res_id_q;
   logic [N_FLAGS-1:0] res_flags;
   logic [7:0]         res_count_q;

   logic [W-1:0]       mux_a;
   logic [W-1:0]       mux_b;
   logic               cmp_eq;
   logic               cmp_gr;
   logic               cmp_le;

   // Requester index k places after base, wrapped into 0..N_REQ-1
   function automatic int wrap_idx(input int base, input int k);
      int s;
      s = base + k;
      return (s >= N_REQ) ? s - N_REQ : s;
   endfunction

   assign res_valid  = (state == ST_FULL);
   // A new result may enter when the slot is empty or drains this cycle
   assign can_accept = !res_valid || bus.res_ready;

   // Round-robin search from rr_ptr; first valid requester wins, none in reset
   always_comb begin
      gnt     = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      if (can_accept && !rst) begin
         for (int k = 0; k < N_REQ; k++) begin
            if (!gnt_any && bus.req_valid[wrap_idx(int'(rr_ptr), k)]) begin
               gnt[wrap_idx(int'(rr_ptr), k)] = 1'b1;
               gnt_id  = IDW'(wrap_idx(int'(rr_ptr), k));
               gnt_any = 1'b1;
            end
         end
      end
   end

   // Pointer moves just past the winner so it becomes lowest priority
   assign nxt_ptr = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;

   // Operand mux feeding the single shared comparator
   assign mux_a = bus.req_a[int'(gnt_id)*W +: W];
   assign mux_b = bus.req_b[int'(gnt_id)*W +: W];

   mag_cmp #(.W(W)) u_cmp (
      .a  (mux_a),
      .b  (mux_b),
      .eq (cmp_eq),
      .gr (cmp_gr),
      .le (cmp_le)
   );

   // Slot FSM, pointer and result register; grant reloads, drain empties
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_EMPTY;
         rr_ptr    <= '0;
         res_id_q  <= '0;
         res_flags <= '0;
      end else if (gnt_any) begin
         state              <= ST_FULL;
         rr_ptr             <= nxt_ptr;
         res_id_q           <= gnt_id;
         res_flags[FLAG_EQ] <= cmp_eq;
         res_flags[FLAG_GR] <= cmp_gr;
         res_flags[FLAG_LE] <= cmp_le;
      end else if (bus.res_ready) begin
         state <= ST_EMPTY;
      end
   end

   // Count delivered results, wrapping at 256
   always_ff @(posedge clk) begin
      if (rst)
         res_count_q <= '0;
      else if (res_valid && bus.res_ready)
         res_count_q <= res_count_q + 8'd1;
   end

   assign bus.req_ready = gnt;
   assign bus.res_valid = res_valid;
   assign bus.res_id    = res_id_q;
   assign bus.res_eq    = res_flags[FLAG_EQ];
   assign bus.res_gr    = res_flags[FLAG_GR];
   assign bus.res_le    = res_flags[FLAG_LE];
   assign bus.res_count = res_count_q;

endmodule

// File: tb/tb_cmp_rr_arbiter.sv
// Bench for cmp_rr_arbiter: scenario tasks with inline checks, plus a
// negedge monitor holding a reference arbiter and a result scoreboard.
`timescale 1ns/1ps
module tb_cmp_rr_arbiter;

   localparam int N_REQ = 4;
   localparam int W     = 4;
   localparam int IDW   = 2;

   typedef struct {
      logic [IDW-1:0] id;
      logic           eq;
      logic           gr;
      logic           le;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   cmp_rr_arbiter_if #(.N_REQ(N_REQ), .W(W)) bus ();

   cmp_rr_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];
   bit   mon_en  = 1'b0;
   int   m_ptr   = 0;
   bit   m_full  = 1'b0;
   int   m_count = 0;
   int   wait_c[N_REQ];

   // Reference arbiter + scoreboard, sampled mid-cycle
   always @(negedge clk) begin
      if (mon_en) begin : mon
         int               eg;
         bit               acc;
         logic [N_REQ-1:0] exp_rdy;
         exp_t             e;
         logic [W-1:0]     a, b;
         acc = !m_full || bus.res_ready;
         eg  = -1;
         if (!rst && acc)
            for (int k = 0; k < N_REQ; k++)
               if (eg < 0 && bus.req_valid[(m_ptr + k) % N_REQ]) eg = (m_ptr + k) % N_REQ;
         exp_rdy = '0;
         if (eg >= 0) exp_rdy[eg] = 1'b1;
         n_tests++;
         if (bus.req_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL mon_req_ready t=%0t got=%b exp=%b", $time, bus.req_ready, exp_rdy);
         end
         n_tests++;
         if (bus.res_valid !== m_full) begin
            n_fail++;
            $display("FAIL mon_res_valid t=%0t got=%b exp=%b", $time, bus.res_valid, m_full);
         end
         if (m_full && sb.size() > 0) begin
            e = sb[0];
            n_tests++;
            if ({bus.res_id, bus.res_eq, bus.res_gr, bus.res_le} !== {e.id, e.eq, e.gr, e.le}) begin
               n_fail++;
               $display("FAIL mon_result t=%0t got id=%0d eq/gr/le=%b%b%b exp id=%0d eq/gr/le=%b%b%b",
                        $time, bus.res_id, bus.res_eq, bus.res_gr, bus.res_le, e.id, e.eq, e.gr, e.le);
            end
         end
         n_tests++;
         if (bus.res_count !== 8'(m_count)) begin
            n_fail++;
            $display("FAIL mon_res_count t=%0t got=%0d exp=%0d", $time, bus.res_count, m_count);
         end
         for (int i = 0; i < N_REQ; i++) begin
            if (rst || !bus.req_valid[i] || eg == i) wait_c[i] = 0;
            else if (acc) wait_c[i]++;
            n_tests++;
            if (wait_c[i] > N_REQ - 1) begin
               n_fail++;
               $display("FAIL mon_starvation t=%0t id=%0d waited=%0d max=%0d", $time, i, wait_c[i], N_REQ - 1);
            end
         end
         if (rst) begin
            m_full  = 1'b0;
            m_ptr   = 0;
            m_count = 0;
            sb.delete();
         end else begin
            if (m_full && bus.res_ready) begin
               m_count = (m_count + 1) % 256;
               void'(sb.pop_front());
            end
            if (eg >= 0) begin
               a    = bus.req_a[eg*W +: W];
               b    = bus.req_b[eg*W +: W];
               e.id = IDW'(eg);
               e.eq = (a == b);
               e.gr = (a > b);
               e.le = (a < b);
               sb.push_back(e);
               m_full = 1'b1;
               m_ptr  = (eg + 1) % N_REQ;
            end else if (bus.res_ready) begin
               m_full = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input int a, input int b);
      bus.req_a[i*W +: W] = W'(a);
      bus.req_b[i*W +: W] = W'(b);
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus.req_valid = '1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_tests++;
         if (bus.req_ready !== 4'b0000 || bus.res_valid !== 1'b0 || bus.res_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset c=%0d got rdy=%b vld=%b cnt=%0d exp rdy=0000 vld=0 cnt=0",
                     c, bus.req_ready, bus.res_valid, bus.res_count);
         end
         tick();
      end
      rst           = 1'b0;
      bus.req_valid = '0;
   endtask

   task automatic test_single();
      bus.res_ready = 1'b1;
      set_op(2, 9, 3);
      bus.req_valid = 4'b0100;
      @(negedge clk);
      n_tests++;
      if (bus.req_ready !== 4'b0100) begin
         n_fail++;
         $display("FAIL single_grant got=%b exp=0100", bus.req_ready);
      end
      tick();
      bus.req_valid = '0;
      @(negedge clk);
      n_tests++;
      if ({bus.res_valid, bus.res_id, bus.res_eq, bus.res_gr, bus.res_le} !== {1'b1, 2'd2, 1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL single_result got vld=%b id=%0d eq/gr/le=%b%b%b exp vld=1 id=2 eq/gr/le=010",
                  bus.res_valid, bus.res_id, bus.res_eq, bus.res_gr, bus.res_le);
      end
      tick();
   endtask

   task automatic test_round_robin();
      int   order[5] = '{0, 1, 2, 3, 0};
      logic ex_eq[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic ex_gr[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic ex_le[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      int   p;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_op(0, 15, 15);
      set_op(1, 0, 1);
      set_op(2, 9, 3);
      set_op(3, 7, 7);
      bus.res_ready = 1'b1;
      bus.req_valid = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k < 5) begin
            n_tests++;
            if (bus.req_ready !== 4'(1 << order[k])) begin
               n_fail++;
               $display("FAIL rr_grant k=%0d got=%b exp id=%0d", k, bus.req_ready, order[k]);
            end
         end
         if (k > 0) begin
            p = order[k-1];
            n_tests++;
            if (bus.res_valid !== 1'b1 || bus.res_id !== IDW'(p) ||
                {bus.res_eq, bus.res_gr, bus.res_le} !== {ex_eq[p], ex_gr[p], ex_le[p]}) begin
               n_fail++;
               $display("FAIL rr_result k=%0d got vld=%b id=%0d eq/gr/le=%b%b%b exp id=%0d eq/gr/le=%b%b%b",
                        k, bus.res_valid, bus.res_id, bus.res_eq, bus.res_gr, bus.res_le,
                        p, ex_eq[p], ex_gr[p], ex_le[p]);
            end
         end
         tick();
         if (k == 4) bus.req_valid = '0;
      end
   endtask

   task automatic test_backpressure();
      set_op(1, 5, 5);
      bus.req_valid = 4'b0010;
      bus.res_ready = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL bp_fill got=%b exp=0010", bus.req_ready);
      end
      tick();
      bus.req_valid = 4'b1101;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_tests++;
         if (bus.req_ready !== 4'b0000 || bus.res_valid !== 1'b1 || bus.res_id !== 2'd1 ||
             {bus.res_eq, bus.res_gr, bus.res_le} !== 3'b100) begin
            n_fail++;
            $display("FAIL bp_hold c=%0d got rdy=%b vld=%b id=%0d eq/gr/le=%b%b%b exp rdy=0000 vld=1 id=1 eq/gr/le=100",
                     c, bus.req_ready, bus.res_valid, bus.res_id, bus.res_eq, bus.res_gr, bus.res_le);
         end
         tick();
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.req_ready !== 4'b0100) begin
         n_fail++;
         $display("FAIL bp_release got=%b exp=0100", bus.req_ready);
      end
      tick();
      bus.req_valid = '0;
      @(negedge clk);
      n_tests++;
      if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd2 || bus.res_gr !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_next got vld=%b id=%0d gr=%b exp vld=1 id=2 gr=1", bus.res_valid, bus.res_id, bus.res_gr);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      set_op(3, 2, 8);
      bus.req_valid = 4'b1000;
      bus.res_ready = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.req_ready !== 4'b1000) begin
         n_fail++;
         $display("FAIL rstmid_fill got=%b exp=1000", bus.req_ready);
      end
      tick();
      rst           = 1'b1;
      bus.req_valid = 4'b0101;
      @(negedge clk);
      n_tests++;
      if (bus.req_ready !== 4'b0000 || bus.res_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_in_reset got rdy=%b vld=%b exp rdy=0000 vld=1", bus.req_ready, bus.res_valid);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.res_valid !== 1'b0 || bus.req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL rstmid_after got vld=%b rdy=%b exp vld=0 rdy=0001", bus.res_valid, bus.req_ready);
      end
      tick();
      bus.req_valid = '0;
      bus.res_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0 || bus.res_eq !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_result got vld=%b id=%0d eq=%b exp vld=1 id=0 eq=1", bus.res_valid, bus.res_id, bus.res_eq);
      end
      tick();
   endtask

   task automatic test_counter_wrap();
      int delivered;
      int cyc;
      rst = 1'b1;
      tick();
      rst           = 1'b0;
      bus.res_ready = 1'b1;
      set_op(0, 3, 12);
      bus.req_valid = 4'b0001;
      delivered = 0;
      cyc       = 0;
      while (delivered < 256 && cyc < 600) begin
         @(negedge clk);
         if (bus.res_valid && bus.res_ready) begin
            if (delivered == 255) begin
               n_tests++;
               if (bus.res_count !== 8'd255) begin
                  n_fail++;
                  $display("FAIL wrap_255 got=%0d exp=255", bus.res_count);
               end
            end
            delivered++;
         end
         tick();
         cyc++;
      end
      n_tests++;
      if (delivered != 256) begin
         n_fail++;
         $display("FAIL wrap_timeout delivered=%0d exp=256", delivered);
      end
      bus.req_valid = '0;
      @(negedge clk);
      n_tests++;
      if (bus.res_count !== 8'd0) begin
         n_fail++;
         $display("FAIL wrap_zero got=%0d exp=0", bus.res_count);
      end
      tick();
   endtask

   task automatic test_random();
      int               grants;
      int               cyc;
      int               a, b;
      logic [N_REQ-1:0] hs;
      grants        = 0;
      cyc           = 0;
      bus.req_valid = '0;
      bus.res_ready = 1'b1;
      while (grants < 1000 && cyc < 6000) begin
         @(negedge clk);
         hs     = bus.req_valid & bus.req_ready;
         grants += $countones(hs);
         tick();
         cyc++;
         for (int i = 0; i < N_REQ; i++) begin
            if (hs[i] || !bus.req_valid[i]) begin
               if ($urandom_range(0, 2) != 0) begin
                  a = int'($urandom_range(0, 15));
                  b = ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, 15));
                  set_op(i, a, b);
                  bus.req_valid[i] = 1'b1;
               end else begin
                  bus.req_valid[i] = 1'b0;
               end
            end
         end
         bus.res_ready = ($urandom_range(0, 3) != 0);
      end
      n_tests++;
      if (grants < 1000) begin
         n_fail++;
         $display("FAIL random_timeout grants=%0d exp>=1000", grants);
      end
      bus.req_valid = '0;
      bus.res_ready = 1'b1;
      repeat (3) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < N_REQ; i++) wait_c[i] = 0;
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.res_ready = 1'b1;
      tick();
      mon_en = 1'b1;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_counter_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
